// File: rtl/mandala_pkg.sv
// Shared types and constants for the mandala frame sequencer and its helpers.
// The palette seed steps a 16-bit Galois LFSR.
package mandala_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_STEP  = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] SEED_INIT_DEFAULT = 16'hACE1;

  // One Galois step; this tap set is maximal length, so a nonzero seed never reaches zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] shifted;
    shifted = s >> 1;
    lfsr_next = s[0] ? (shifted ^ LFSR_TAPS) : shifted;
  endfunction

endpackage

// File: rtl/mandala_input_sync.sv
// Two-flop synchroniser for asynchronous pins, with an optional rising-edge
// detector taken after the synchronised stage.
module mandala_input_sync
  import mandala_pkg::*;
#(
  parameter int W    = 1,
  parameter bit EDGE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

  generate
    if (EDGE) begin : g_edge
      logic [W-1:0] prev;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev <= '0;
        end else begin
          prev <= q;
        end
      end

      assign rise = q & ~prev;
    end else begin : g_no_edge
      assign rise = '0;
    end
  endgenerate

endmodule

// File: rtl/mandala_frame_sequencer.sv
// Frame-synchronous controller: owns animation phase, ring mode and palette
// reseed schedule; player controls take effect only on a vsync frame tick.
module mandala_frame_sequencer
  import mandala_pkg::*;
#(
  parameter int          PHASE_W     = 8,
  parameter int          HOLD_FRAMES = 60,
  parameter logic [15:0] SEED_INIT   = SEED_INIT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync_i,
  input  logic               run_i,
  input  logic               step_i,
  input  logic [2:0]         speed_i,
  input  logic [1:0]         mode_i,
  output logic [PHASE_W-1:0] phase_o,
  output logic [1:0]         mode_o,
  output logic [15:0]        seed_o,
  output logic               seed_load_o,
  output logic               frame_tick_o,
  output logic [1:0]         state_o
);

  localparam int               CNT_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_FRAMES - 1);

  logic [1:0]         rst_pipe;
  logic               rst_n_sync;

  logic               run_s;
  logic               step_rise;
  logic [2:0]         speed_s;
  logic [1:0]         mode_s;
  logic               run_rise_unused;
  logic               step_level_unused;
  logic [2:0]         speed_rise_unused;
  logic [1:0]         mode_rise_unused;

  logic               vsync_prev;
  logic               tick;
  logic               tick_q;

  state_t             state_q;
  state_t             state_d;

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_inc;
  logic [1:0]         mode_q;
  logic [2:0]         speed_sh;
  logic [CNT_W-1:0]   cnt_q;
  logic               cnt_adv;
  logic               reseed;
  logic               reseed_q;
  logic [15:0]        seed_q;
  logic               seed_load_q;

  logic               step_pending_q;
  logic               step_edge_ok;
  logic               step_req;
  logic               step_take;

  // Reset asserts asynchronously but leaves the design two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_n_sync = rst_pipe[1];

  mandala_input_sync #(.W(1), .EDGE(1'b0)) u_sync_run (
    .clk   (clk),
    .rst_n (rst_n_sync),
    .d     (run_i),
    .q     (run_s),
    .rise  (run_rise_unused)
  );

  mandala_input_sync #(.W(1), .EDGE(1'b1)) u_sync_step (
    .clk   (clk),
    .rst_n (rst_n_sync),
    .d     (step_i),
    .q     (step_level_unused),
    .rise  (step_rise)
  );

  mandala_input_sync #(.W(3), .EDGE(1'b0)) u_sync_speed (
    .clk   (clk),
    .rst_n (rst_n_sync),
    .d     (speed_i),
    .q     (speed_s),
    .rise  (speed_rise_unused)
  );

  mandala_input_sync #(.W(2), .EDGE(1'b0)) u_sync_mode (
    .clk   (clk),
    .rst_n (rst_n_sync),
    .d     (mode_i),
    .q     (mode_s),
    .rise  (mode_rise_unused)
  );

  assign tick         = vsync_i && !vsync_prev;
  assign step_edge_ok = step_rise && (state_q != ST_RUN);
  assign step_req     = step_pending_q || step_edge_ok;
  assign reseed       = cnt_adv && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        ST_IDLE:  if (run_s) state_d = ST_RUN;
        ST_RUN:   if (!run_s) state_d = ST_PAUSE;
        ST_PAUSE: begin
          if (run_s) begin
            state_d = ST_RUN;
          end else if (step_req) begin
            state_d = ST_STEP;
          end
        end
        ST_STEP:  state_d = run_s ? ST_RUN : ST_PAUSE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Frame actions are decided from the pre-tick state and the pre-tick shadow speed.
  always_comb begin
    phase_inc = '0;
    cnt_adv   = 1'b0;
    step_take = 1'b0;
    if (tick) begin
      case (state_q)
        ST_RUN: begin
          if (run_s) begin
            phase_inc = PHASE_W'(speed_sh) + PHASE_W'(1);
            cnt_adv   = 1'b1;
          end
        end
        ST_STEP:  phase_inc = PHASE_W'(1);
        ST_PAUSE: step_take = !run_s && step_req;
        default:  phase_inc = '0;
      endcase
    end
  end

  // vsync_prev resets high so a vsync already high at reset release cannot fake a rise.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      vsync_prev     <= 1'b1;
      tick_q         <= 1'b0;
      phase_q        <= '0;
      mode_q         <= '0;
      speed_sh       <= '0;
      cnt_q          <= '0;
      seed_q         <= SEED_INIT;
      reseed_q       <= 1'b0;
      seed_load_q    <= 1'b0;
      step_pending_q <= 1'b0;
    end else begin
      vsync_prev     <= vsync_i;
      tick_q         <= tick;
      phase_q        <= phase_q + phase_inc;
      reseed_q       <= reseed;
      seed_load_q    <= reseed_q;
      step_pending_q <= step_take ? 1'b0 : step_req;
      if (tick) begin
        speed_sh <= speed_s;
        mode_q   <= mode_s;
      end
      if (reseed) begin
        cnt_q  <= '0;
        seed_q <= lfsr_next(seed_q);
      end else if (cnt_adv) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign phase_o      = phase_q;
  assign mode_o       = mode_q;
  assign seed_o       = seed_q;
  assign seed_load_o  = seed_load_q;
  assign frame_tick_o = tick_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_mandala_frame_sequencer.sv
// Directed self-checking bench for mandala_frame_sequencer (HOLD_FRAMES=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mandala_frame_sequencer;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_STEP  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        vsync_i = 1'b0;
  logic        run_i = 1'b0;
  logic        step_i = 1'b0;
  logic [2:0]  speed_i = 3'd0;
  logic [1:0]  mode_i = 2'd0;
  logic [7:0]  phase_o;
  logic [1:0]  mode_o;
  logic [15:0] seed_o;
  logic        seed_load_o;
  logic        frame_tick_o;
  logic [1:0]  state_o;

  int          n_compared = 0;
  int          n_mismatched = 0;
  bit          tick_at0, tick_at1, tick_at2, load_at2;
  logic [15:0] seed_at2;
  int          frame_ticks;
  int          load_total = 0;
  int          ticks_seen;

  mandala_frame_sequencer #(
    .PHASE_W     (8),
    .HOLD_FRAMES (4),
    .SEED_INIT   (16'hACE1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vsync_i      (vsync_i),
    .run_i        (run_i),
    .step_i       (step_i),
    .speed_i      (speed_i),
    .mode_i       (mode_i),
    .phase_o      (phase_o),
    .mode_o       (mode_o),
    .seed_o       (seed_o),
    .seed_load_o  (seed_load_o),
    .frame_tick_o (frame_tick_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_frame(input string tag, input int exp_phase, input int exp_state);
    check_output({tag, ".phase"}, 32'(phase_o), 32'(exp_phase));
    check_output({tag, ".state"}, 32'(state_o), 32'(exp_state));
  endtask

  // Raise vsync for 'hold' clocks, then keep it low for five more, recording pulses.
  task automatic apply_stimulus(input int hold);
    tick_at0    = frame_tick_o;
    tick_at1    = 1'b0;
    tick_at2    = 1'b0;
    load_at2    = 1'b0;
    seed_at2    = '0;
    frame_ticks = 0;
    vsync_i     = 1'b1;
    for (int c = 1; c <= hold + 5; c++) begin
      @(negedge clk);
      if (frame_tick_o) frame_ticks++;
      if (seed_load_o) load_total++;
      if (c == 1) tick_at1 = frame_tick_o;
      if (c == 2) begin
        tick_at2 = frame_tick_o;
        load_at2 = seed_load_o;
        seed_at2 = seed_o;
      end
      if (c == hold) vsync_i = 1'b0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, ".phase"}, 32'(phase_o), 32'd0);
    check_output({tag, ".mode"}, 32'(mode_o), 32'd0);
    check_output({tag, ".seed"}, 32'(seed_o), 32'hACE1);
    check_output({tag, ".load"}, 32'(seed_load_o), 32'd0);
    check_output({tag, ".tick"}, 32'(frame_tick_o), 32'd0);
    check_output({tag, ".state"}, 32'(state_o), 32'(S_IDLE));
  endtask

  initial begin
    $display("[TB] mandala_frame_sequencer directed run");
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Idle frames with run low, then one long vsync that must tick only once.
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(3);
      check_output("idle.tick", 32'(tick_at1), 32'd1);
      check_frame("idle", 0, S_IDLE);
    end
    apply_stimulus(10);
    check_output("idle.long_vsync_ticks", 32'(frame_ticks), 32'd1);
    check_output("idle.no_load", 32'(load_total), 32'd0);

    // Run at speed 2: entry frame holds phase, then +3 per frame; fourth run frame reseeds.
    run_i = 1'b1; speed_i = 3'd2; mode_i = 2'd1;
    repeat (4) @(negedge clk);
    apply_stimulus(3);
    check_output("run.tick_before", 32'(tick_at0), 32'd0);
    check_output("run.tick_after1", 32'(tick_at1), 32'd1);
    check_output("run.tick_after2", 32'(tick_at2), 32'd0);
    check_output("run.mode", 32'(mode_o), 32'd1);
    check_frame("run.entry", 0, S_RUN);
    for (int k = 1; k <= 4; k++) begin
      apply_stimulus(3);
      check_frame("run.adv", 3 * k, S_RUN);
    end
    check_output("reseed1.load_at2", 32'(load_at2), 32'd1);
    check_output("reseed1.seed", 32'(seed_o), 32'hE270);
    check_output("reseed1.count", 32'(load_total), 32'd1);
    for (int k = 5; k <= 8; k++) begin
      apply_stimulus(3);
      check_frame("run.adv", 3 * k, S_RUN);
    end
    check_output("reseed2.load_at2", 32'(load_at2), 32'd1);
    check_output("reseed2.seed_stable", 32'(seed_at2), 32'h7138);
    check_output("reseed2.count", 32'(load_total), 32'd2);

    // Pause, then three step edges in one frame collapse into a single step.
    run_i = 1'b0;
    repeat (4) @(negedge clk);
    apply_stimulus(3);
    check_frame("pause.enter", 24, S_PAUSE);
    for (int k = 0; k < 3; k++) begin
      step_i = 1'b1;
      repeat (3) @(negedge clk);
      step_i = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    apply_stimulus(3);
    check_frame("step.enter", 24, S_STEP);
    apply_stimulus(3);
    check_frame("step.leave", 25, S_PAUSE);
    apply_stimulus(3);
    check_frame("step.collapsed", 25, S_PAUSE);

    // Step edge reaching the FSM in the same cycle as the tick is consumed by it.
    step_i = 1'b1;
    repeat (2) @(negedge clk);
    apply_stimulus(3);
    check_frame("step_on_tick.enter", 25, S_STEP);
    apply_stimulus(3);
    check_frame("step_on_tick.leave", 26, S_PAUSE);
    apply_stimulus(3);
    check_frame("step_on_tick.no_repeat", 26, S_PAUSE);

    // A step edge while running is dropped.
    run_i = 1'b1; step_i = 1'b0;
    repeat (4) @(negedge clk);
    apply_stimulus(3);
    check_frame("resume", 26, S_RUN);
    step_i = 1'b1;
    repeat (4) @(negedge clk);
    apply_stimulus(3);
    check_frame("run.step_edge", 29, S_RUN);
    run_i = 1'b0;
    repeat (4) @(negedge clk);
    apply_stimulus(3);
    check_frame("run.pause_again", 29, S_PAUSE);
    apply_stimulus(3);
    check_frame("run.step_dropped", 29, S_PAUSE);

    // Mode only moves on a tick.
    mode_i = 2'd3;
    repeat (6) @(negedge clk);
    check_output("mode.between_ticks", 32'(mode_o), 32'd1);
    apply_stimulus(3);
    check_output("mode.on_tick", 32'(mode_o), 32'd3);

    // Fresh reset, then drive the phase to 250 and wrap with speed 7.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_i = 1'b1; speed_i = 3'd1;
    repeat (4) @(negedge clk);
    apply_stimulus(3);
    check_frame("wrap.entry", 0, S_RUN);
    speed_i = 3'd7;
    repeat (4) @(negedge clk);
    apply_stimulus(3);
    check_frame("wrap.first", 2, S_RUN);
    for (int k = 0; k < 31; k++) apply_stimulus(3);
    check_frame("wrap.near", 250, S_RUN);
    apply_stimulus(3);
    check_frame("wrap.over", 2, S_RUN);
    check_output("wrap.mode", 32'(mode_o), 32'd3);

    // Mid-line reset with vsync held high across release: no tick until a fresh rise.
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    vsync_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    ticks_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (frame_tick_o) ticks_seen++;
    end
    check_output("midreset.held_vsync_ticks", 32'(ticks_seen), 32'd0);
    check_output("midreset.state", 32'(state_o), 32'(S_IDLE));
    vsync_i = 1'b0;
    repeat (3) @(negedge clk);
    apply_stimulus(3);
    check_output("midreset.fresh_tick", 32'(tick_at1), 32'd1);
    check_frame("midreset.run", 0, S_RUN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
